stripes_mult_array: RTL

Parametrised multi-lane bit-serial (Stripes-style) multiplier. Successor to the single-lane generic serial multiplier: LANES signed products per transaction, runtime precision, true two's-complement multiplier handling, early termination on leading zeros, and an optional running dot-product accumulator. Sits in the multiplier generator library and feeds PE arrays through a valid/ready handshake.

---
 rtl/stripes_pkg.sv | 20 ++
 rtl/stripes_lane.sv | 68 ++++++
 rtl/stripes_mult_array.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/stripes_pkg.sv
// Shared types and helpers for the Stripes-style
// bit-serial multiplier array.
package stripes_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   function automatic int prec_w(input int w);
      return $clog2(w + 1);
   endfunction

   // 0 or anything wider than the operand means full width
   function automatic int clamp_prec(input int p, input int w);
      return (p == 0 || p > w) ? w : p;
   endfunction

endpackage

// File: rtl/stripes_lane.sv
// One lane: latched operands, serial shift-add/sub
// partial product and a "no more set bits" flag.
module stripes_lane
   import stripes_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int PW    = prec_w(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               step_i,
   input  logic [PW-1:0]      k_i,
   input  logic [PW-1:0]      p_i,
   input  logic [WIDTH-1:0]   jia_i,
   input  logic [WIDTH-1:0]   yi_i,
   output logic [2*WIDTH-1:0] part_nxt_o,
   output logic               rz_o
);

   localparam int DW = 2 * WIDTH;

   logic [DW-1:0]    jia_q, jia_d;
   logic [DW-1:0]    part_q, part_d;
   logic [DW-1:0]    term;
   logic [WIDTH-1:0] yi_q, yi_d;
   logic [WIDTH-1:0] mask;
   logic             bit_k;
   logic             last;

   // Load operands or accumulate the weighted multiplicand for bit k
   always_comb begin
      jia_d = jia_q;
      yi_d  = yi_q;
      part_d = part_q;
      bit_k = 1'b0;
      mask  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i == int'(k_i)) bit_k = yi_q[i];
         mask[i] = (i > int'(k_i)) && (i < int'(p_i));
      end
      term = jia_q << k_i;
      last = (int'(k_i) + 1 == int'(p_i));
      if (load_i) begin
         jia_d  = {{WIDTH{jia_i[WIDTH-1]}}, jia_i};
         yi_d   = yi_i;
         part_d = '0;
      end else if (step_i && bit_k) begin
         part_d = last ? part_q - term : part_q + term;
      end
      part_nxt_o = part_d;
      rz_o = ~|(yi_q & mask);
   end

   // Lane registers
   always_ff @(posedge clk) begin
      if (rst) begin
         jia_q  <= '0;
         yi_q   <= '0;
         part_q <= '0;
      end else begin
         jia_q  <= jia_d;
         yi_q   <= yi_d;
         part_q <= part_d;
      end
   end

endmodule

// File: rtl/stripes_mult_array.sv
// Multi-lane bit-serial signed multiplier with early
// termination and optional dot-product accumulator.
module stripes_mult_array
   import stripes_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LANES = 4,
   parameter int ACC_W = 2 * WIDTH + $clog2(LANES) + 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [prec_w(WIDTH)-1:0]   precision,
   input  logic                       acc_mode,
   input  logic                       acc_clear,
   input  logic [LANES*WIDTH-1:0]     jia,
   input  logic [LANES*WIDTH-1:0]     yi,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*2*WIDTH-1:0]   zi,
   output logic [ACC_W-1:0]           dot
);

   localparam int PW = prec_w(WIDTH);
   localparam int DW = 2 * WIDTH;

   state_e state_q, state_d;

   logic [PW-1:0]       k_q, k_d;
   logic [PW-1:0]       p_q, p_d;
   logic                mode_q, mode_d;
   logic                clr_q, clr_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [ACC_W-1:0]    dot_q, dot_d;
   logic [ACC_W-1:0]    sum, base, tot;
   logic [LANES*DW-1:0] zi_q, zi_d;
   logic [LANES*DW-1:0] part_nxt;
   logic [LANES-1:0]    rz;
   logic                accept;
   logic                step;

   assign in_ready = en & ((state_q == IDLE) |
                           ((state_q == DONE) & out_ready));
   assign accept   = in_valid & in_ready;
   assign step     = en & (state_q == RUN);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      stripes_lane #(
         .WIDTH (WIDTH),
         .PW    (PW)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .load_i     (accept),
         .step_i     (step),
         .k_i        (k_q),
         .p_i        (p_q),
         .jia_i      (jia[g*WIDTH +: WIDTH]),
         .yi_i       (yi[g*WIDTH +: WIDTH]),
         .part_nxt_o (part_nxt[g*DW +: DW]),
         .rz_o       (rz[g])
      );
   end

   // Sign-extended sum of the lane partials after this step
   always_comb begin
      sum = '0;
      for (int l = 0; l < LANES; l++) begin
         sum = sum + {{(ACC_W-DW){part_nxt[l*DW+DW-1]}},
                      part_nxt[l*DW +: DW]};
      end
      base = clr_q ? '0 : acc_q;
      tot  = base + sum;
   end

   // FSM next state, bit counter, result capture
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      p_d     = p_q;
      mode_d  = mode_q;
      clr_d   = clr_q;
      acc_d   = acc_q;
      dot_d   = dot_q;
      zi_d    = zi_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = RUN;
         end
         RUN: begin
            if (step) begin
               if (&rz) begin
                  state_d = DONE;
                  zi_d    = part_nxt;
                  dot_d   = mode_q ? tot : sum;
                  if (mode_q) acc_d = tot;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         DONE: begin
            if (en && out_ready) state_d = accept ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         k_d    = '0;
         p_d    = PW'(clamp_prec(int'(precision), WIDTH));
         mode_d = acc_mode;
         clr_d  = acc_clear;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         p_q     <= '0;
         mode_q  <= 1'b0;
         clr_q   <= 1'b0;
         acc_q   <= '0;
         dot_q   <= '0;
         zi_q    <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         p_q     <= p_d;
         mode_q  <= mode_d;
         clr_q   <= clr_d;
         acc_q   <= acc_d;
         dot_q   <= dot_d;
         zi_q    <= zi_d;
      end
   end

   assign out_valid = (state_q == DONE);
   assign zi        = zi_q;
   assign dot       = dot_q;

endmodule
